// File: rtl/water_alarm_controller_if.sv
// Operator-side signal bundle for water_alarm_controller: fault/alert/ack in, alarm status out.
interface water_alarm_controller_if;
  logic [1:0] water_quality;
  logic       alert;
  logic       ack;
  logic       alarm;
  logic       buzzer;
  logic [1:0] alarm_state;
  logic [1:0] fault_code;
  logic [7:0] event_count;

  modport master (
    output water_quality, alert, ack,
    input  alarm, buzzer, alarm_state, fault_code, event_count
  );

  modport slave (
    input  water_quality, alert, ack,
    output alarm, buzzer, alarm_state, fault_code, event_count
  );
endinterface

// File: rtl/water_alarm_controller.sv
// Alarm FSM: confirms a sustained alert, latches the fault, pulses the buzzer, waits for ack/clear.
// Optional macro ALARM_AUTO_CLEAR_EN: ALARM also drops to HOLD after CLEAR_CYCLES quiet cycles.
module water_alarm_controller #(
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES   = 8,
  parameter int unsigned BUZZ_PERIOD    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  water_alarm_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    ALARM   = 2'b10,
    HOLD    = 2'b11
  } state_e;

  localparam logic [7:0] CONF_LAST  = 8'(CONFIRM_CYCLES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] BUZZ_LAST  = 8'(BUZZ_PERIOD - 1);

  state_e     state_q, state_d;
  logic [7:0] confirm_q, confirm_d;
  logic [7:0] clear_q, clear_d;
  logic [7:0] buzz_cnt_q, buzz_cnt_d;
  logic       alarm_q, alarm_d;
  logic       buzzer_q, buzzer_d;
  logic [1:0] fault_q, fault_d;
  logic [7:0] event_q, event_d;
  logic       raise, rearm, go_hold;

  always_comb begin
    state_d    = state_q;
    confirm_d  = confirm_q;
    clear_d    = clear_q;
    buzz_cnt_d = buzz_cnt_q;
    alarm_d    = alarm_q;
    buzzer_d   = buzzer_q;
    fault_d    = fault_q;
    event_d    = event_q;
    raise      = 1'b0;
    rearm      = 1'b0;
    go_hold    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.alert) begin
          if (CONF_LAST == '0) begin
            raise = 1'b1;
          end else begin
            state_d   = PENDING;
            confirm_d = 8'd1;
          end
        end
      end
      PENDING: begin
        if (!bus.alert) begin
          state_d   = IDLE;
          confirm_d = '0;
        end else if (confirm_q == CONF_LAST) begin
          raise = 1'b1;
        end else begin
          confirm_d = confirm_q + 8'd1;
        end
      end
      ALARM: begin
        if (buzz_cnt_q == BUZZ_LAST) begin
          buzz_cnt_d = '0;
          buzzer_d   = ~buzzer_q;
        end else begin
          buzz_cnt_d = buzz_cnt_q + 8'd1;
        end
`ifdef ALARM_AUTO_CLEAR_EN
        if (bus.alert) begin
          clear_d = '0;
        end else if (clear_q == CLEAR_LAST) begin
          go_hold = 1'b1;
        end else begin
          clear_d = clear_q + 8'd1;
        end
`endif
        if (bus.ack && !bus.alert) begin
          go_hold = 1'b1;
        end
      end
      HOLD: begin
        if (bus.alert) begin
          rearm = 1'b1;
        end else if (clear_q == CLEAR_LAST) begin
          state_d = IDLE;
          clear_d = '0;
          fault_d = '0;
        end else begin
          clear_d = clear_q + 8'd1;
        end
      end
    endcase

    // Entry into ALARM is shared by a fresh confirmation and a re-alert from HOLD;
    // only a fresh confirmation latches the fault and counts an event.
    if (raise || rearm) begin
      state_d    = ALARM;
      alarm_d    = 1'b1;
      buzzer_d   = 1'b1;
      buzz_cnt_d = '0;
      clear_d    = '0;
      confirm_d  = '0;
    end
    if (raise) begin
      fault_d = bus.water_quality;
      if (event_q != 8'hFF) begin
        event_d = event_q + 8'd1;
      end
    end
    if (go_hold) begin
      state_d    = HOLD;
      alarm_d    = 1'b0;
      buzzer_d   = 1'b0;
      buzz_cnt_d = '0;
      clear_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      confirm_q  <= '0;
      clear_q    <= '0;
      buzz_cnt_q <= '0;
      alarm_q    <= 1'b0;
      buzzer_q   <= 1'b0;
      fault_q    <= '0;
      event_q    <= '0;
    end else begin
      state_q    <= state_d;
      confirm_q  <= confirm_d;
      clear_q    <= clear_d;
      buzz_cnt_q <= buzz_cnt_d;
      alarm_q    <= alarm_d;
      buzzer_q   <= buzzer_d;
      fault_q    <= fault_d;
      event_q    <= event_d;
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.buzzer      = buzzer_q;
  assign bus.alarm_state = state_q;
  assign bus.fault_code  = fault_q;
  assign bus.event_count = event_q;

endmodule

// File: tb/tb_water_alarm_controller.sv
// Scoreboard bench: two configurations driven in lockstep, expectations from a run-length model.
module tb_water_alarm_controller;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  water_alarm_controller_if bus0 ();
  water_alarm_controller_if bus1 ();

  water_alarm_controller #(
    .CONFIRM_CYCLES (4),
    .CLEAR_CYCLES   (8),
    .BUZZ_PERIOD    (4)
  ) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  water_alarm_controller #(
    .CONFIRM_CYCLES (1),
    .CLEAR_CYCLES   (2),
    .BUZZ_PERIOD    (1)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

`ifdef ALARM_AUTO_CLEAR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'b00, ST_PEND = 2'b01, ST_ALARM = 2'b10, ST_HOLD = 2'b11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: consecutive-run counters and cycles-since-entry per configuration.
  logic [1:0]  m_state [2];
  int unsigned m_run   [2];
  int unsigned m_low   [2];
  int unsigned m_since [2];
  logic [1:0]  m_fault [2];
  int unsigned m_events[2];

  logic [14:0] exp_q0[$];
  logic [14:0] exp_q1[$];

  function automatic int unsigned conf_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction
  function automatic int unsigned clr_of(input int k);
    return (k == 0) ? 8 : 2;
  endfunction
  function automatic int unsigned bp_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic enter_new(input int k, input logic [1:0] wq);
    m_state[k] = ST_ALARM;
    m_since[k] = 0;
    m_low[k]   = 0;
    m_run[k]   = 0;
    m_fault[k] = wq;
    if (m_events[k] < 255) m_events[k] = m_events[k] + 1;
  endtask

  task automatic model_step(input int k, input logic rst, input logic a, input logic ak,
                            input logic [1:0] wq, output logic [14:0] expv);
    logic al, bz;
    if (rst) begin
      m_state[k] = ST_IDLE; m_run[k] = 0; m_low[k] = 0; m_since[k] = 0;
      m_fault[k] = 2'b00;   m_events[k] = 0;
    end else begin
      case (m_state[k])
        ST_IDLE: if (a) begin
          m_run[k] = 1;
          if (m_run[k] >= conf_of(k)) enter_new(k, wq);
          else m_state[k] = ST_PEND;
        end
        ST_PEND: if (!a) begin
          m_state[k] = ST_IDLE; m_run[k] = 0;
        end else begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] >= conf_of(k)) enter_new(k, wq);
        end
        ST_ALARM: begin
          m_since[k] = m_since[k] + 1;
          m_low[k]   = a ? 0 : m_low[k] + 1;
          if ((ak && !a) || (AUTO && m_low[k] >= clr_of(k))) begin
            m_state[k] = ST_HOLD; m_low[k] = 0;
          end
        end
        default: if (a) begin
          m_state[k] = ST_ALARM; m_since[k] = 0; m_low[k] = 0;
        end else begin
          m_low[k] = m_low[k] + 1;
          if (m_low[k] >= clr_of(k)) begin
            m_state[k] = ST_IDLE; m_fault[k] = 2'b00; m_low[k] = 0;
          end
        end
      endcase
    end
    al = (m_state[k] == ST_ALARM);
    bz = al && (((m_since[k] / bp_of(k)) % 2) == 0);
    expv = {m_state[k], al, bz, m_fault[k], 8'(m_events[k])};
  endtask

  task automatic drive(input logic rst, input logic a, input logic ak, input logic [1:0] wq);
    logic [14:0] e0, e1;
    @(negedge clk);
    reset = rst;
    bus0.alert = a; bus0.ack = ak; bus0.water_quality = wq;
    bus1.alert = a; bus1.ack = ak; bus1.water_quality = wq;
    model_step(0, rst, a, ak, wq, e0);
    model_step(1, rst, a, ak, wq, e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
  endtask

  task automatic drive_n(input int n, input logic a, input logic ak, input logic [1:0] wq);
    for (int i = 0; i < n; i++) drive(1'b0, a, ak, wq);
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic cmp_obs(input string name, input logic [14:0] got, input logic [14:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s t=%0t got st=%b al=%b bz=%b fc=%b ev=%0d expected st=%b al=%b bz=%b fc=%b ev=%0d",
               name, $time, got[14:13], got[12], got[11], got[10:9], got[7:0],
               e[14:13], e[12], e[11], e[10:9], e[7:0]);
    end
  endtask

  // Monitor: outputs are registered and valid every cycle after each edge.
  initial begin
    logic [14:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        cmp_obs("dut0_outputs", {bus0.alarm_state, bus0.alarm, bus0.buzzer, bus0.fault_code,
                                 bus0.event_count}, e);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        cmp_obs("dut1_outputs", {bus1.alarm_state, bus1.alarm, bus1.buzzer, bus1.fault_code,
                                 bus1.event_count}, e);
      end
    end
  end

  initial begin
    logic a, ak, rst;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus0.alert = 1'b0; bus0.ack = 1'b0; bus0.water_quality = 2'b00;
    bus1.alert = 1'b0; bus1.ack = 1'b0; bus1.water_quality = 2'b00;

    drive(1'b1, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 2'b11);
    post();
    chk("reset_state", int'(bus0.alarm_state), 0);
    chk("reset_events", int'(bus0.event_count), 0);

    // Short alert burst: never confirms
    drive_n(3, 1'b1, 1'b0, 2'b10);
    post();
    chk("burst_pending", int'(bus0.alarm_state), 1);
    drive(1'b0, 1'b0, 1'b0, 2'b10);
    post();
    chk("burst_idle", int'(bus0.alarm_state), 0);
    chk("burst_alarm", int'(bus0.alarm), 0);
    chk("burst_events", int'(bus0.event_count), 0);

    // Confirmed alarm with pH fault, buzzer pattern
    drive_n(4, 1'b1, 1'b0, 2'b01);
    post();
    chk("raise_alarm", int'(bus0.alarm), 1);
    chk("raise_fault", int'(bus0.fault_code), 1);
    chk("raise_events", int'(bus0.event_count), 1);
    chk("raise_buzz0", int'(bus0.buzzer), 1);
    drive_n(4, 1'b1, 1'b0, 2'b11);
    post();
    chk("buzz_after_period", int'(bus0.buzzer), 0);
    chk("fault_held", int'(bus0.fault_code), 1);

    // Ack ignored while alert high; accepted when low
    drive_n(2, 1'b1, 1'b1, 2'b00);
    post();
    chk("ack_ignored", int'(bus0.alarm_state), 2);
    drive(1'b0, 1'b0, 1'b1, 2'b00);
    post();
    chk("ack_hold", int'(bus0.alarm_state), 3);
    chk("hold_buzzer", int'(bus0.buzzer), 0);
    drive_n(7, 1'b0, 1'b0, 2'b10);
    post();
    chk("hold_7low", int'(bus0.alarm_state), 3);
    drive(1'b0, 1'b0, 1'b0, 2'b10);
    post();
    chk("hold_cleared", int'(bus0.alarm_state), 0);
    chk("hold_fault_clr", int'(bus0.fault_code), 0);

    // Re-alert from HOLD: no reconfirmation, no new event
    drive_n(4, 1'b1, 1'b0, 2'b10);
    drive(1'b0, 1'b0, 1'b1, 2'b00);
    drive_n(3, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 1'b0, 2'b01);
    post();
    chk("rearm_state", int'(bus0.alarm_state), 2);
    chk("rearm_events", int'(bus0.event_count), 2);
    chk("rearm_fault", int'(bus0.fault_code), 2);
    chk("rearm_buzz", int'(bus0.buzzer), 1);

    // Quiet ALARM without ack: leaves only when auto-clear is built in
    drive_n(8, 1'b0, 1'b0, 2'b00);
    post();
    chk("quiet_alarm", int'(bus0.alarm_state), AUTO ? 3 : 2);

    // Reset beats alert, mid-ALARM and mid-PENDING
    drive(1'b0, 1'b1, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 2'b11);
    post();
    chk("rst_alarm_state", int'(bus0.alarm_state), 0);
    chk("rst_alarm_out", int'({bus0.alarm, bus0.buzzer, bus0.fault_code}), 0);
    chk("rst_alarm_events", int'(bus0.event_count), 0);
    drive_n(2, 1'b1, 1'b0, 2'b01);
    drive(1'b1, 1'b1, 1'b0, 2'b01);
    drive_n(3, 1'b1, 1'b0, 2'b01);
    post();
    chk("rst_pend_restart", int'(bus0.alarm_state), 1);
    drive(1'b0, 1'b0, 1'b0, 2'b00);

    // 256 confirmed events: counter saturates
    for (int n = 0; n < 256; n++) begin
      drive_n(4, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
      drive(1'b0, 1'b0, 1'b1, 2'b00);
      drive_n(8, 1'b0, 1'b0, 2'b00);
    end
    post();
    chk("events_saturate", int'(bus0.event_count), 255);

    // Randomized traffic with sticky alert runs
    a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      ak  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) == 0);
      drive(rst, a, ak, 2'($urandom_range(0, 3)));
    end

    post();
    #2;
    chk("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
